// File: rtl/riscoffee_mcsr_if.sv
// CSR access bus between the decoder (master) and the machine-mode CSR unit (slave).
// Read data and the illegal flag come back registered, one cycle after CSR_VALID.
interface riscoffee_mcsr_if;
    logic        CSR_VALID;
    logic [1:0]  CSR_OP;
    logic        CSR_NOWR;
    logic [11:0] CSR_ADDR;
    logic [31:0] CSR_WDATA;
    logic [31:0] CSR_RDATA;
    logic        CSR_ILLEGAL;

    modport master (
        output CSR_VALID, CSR_OP, CSR_NOWR, CSR_ADDR, CSR_WDATA,
        input  CSR_RDATA, CSR_ILLEGAL
    );

    modport slave (
        input  CSR_VALID, CSR_OP, CSR_NOWR, CSR_ADDR, CSR_WDATA,
        output CSR_RDATA, CSR_ILLEGAL
    );
endinterface

// File: rtl/riscoffee_mcsr.sv
// Sparse machine-mode CSR unit: atomic RW/RS/RC with old-value return, illegal-access
// detection, 64-bit cycle/instret counters, and trap entry / MRET status updates.
module riscoffee_mcsr #(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          CNT_W       = 64
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    riscoffee_mcsr_if.slave        csr,
    input  logic                   INSTRET,
    input  logic                   TRAP,
    input  logic [31:0]            TRAP_PC,
    input  logic [31:0]            TRAP_CAUSE,
    input  logic [31:0]            TRAP_TVAL,
    input  logic                   MRET,
    output logic [31:0]            MTVEC_OUT,
    output logic [31:0]            MEPC_OUT,
    output logic                   MIE_OUT
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0]  OP_RW = 2'b01;
    localparam logic [1:0]  OP_RS = 2'b10;
    localparam logic [1:0]  OP_RC = 2'b11;

    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] MTVEC_RST  = MTVEC_RESET & ALIGN_MASK;
    // Counters live in 64-bit registers; bits at and above CNT_W are held at zero.
    localparam logic [63:0] CNT_MASK   = (CNT_W >= 64) ? {64{1'b1}}
                                                       : ((64'd1 << CNT_W) - 64'd1);

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic [63:0] mcycle_reg;
    logic [63:0] minstret_reg;
    logic [31:0] rdata_reg;
    logic        illegal_reg;

    logic [31:0] mstatus_rd;
    logic [31:0] rd_val;
    logic        addr_hit;
    logic        does_write;
    logic        illegal;
    logic        wr_en;
    logic [31:0] new_val;
    logic [63:0] mcycle_nxt;
    logic [63:0] minstret_nxt;

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

    always_comb begin
        rd_val   = 32'h0;
        addr_hit = 1'b1;
        case (csr.CSR_ADDR)
            A_MSTATUS:                rd_val = mstatus_rd;
            A_MISA:                   rd_val = MISA_VALUE;
            A_MIE:                    rd_val = mie_reg;
            A_MTVEC:                  rd_val = mtvec_reg;
            A_MSCRATCH:               rd_val = mscratch_reg;
            A_MEPC:                   rd_val = mepc_reg;
            A_MCAUSE:                 rd_val = mcause_reg;
            A_MTVAL:                  rd_val = mtval_reg;
            A_MIP:                    rd_val = 32'h0;
            A_MCYCLE, A_CYCLE:        rd_val = mcycle_reg[31:0];
            A_MCYCLEH, A_CYCLEH:      rd_val = mcycle_reg[63:32];
            A_MINSTRET, A_INSTRET:    rd_val = minstret_reg[31:0];
            A_MINSTRETH, A_INSTRETH:  rd_val = minstret_reg[63:32];
            A_MVENDORID, A_MARCHID,
            A_MIMPID:                 rd_val = 32'h0;
            A_MHARTID:                rd_val = HART_ID;
            default:                  addr_hit = 1'b0;
        endcase
    end

    // RS/RC with a zero rs1/uimm field are pure reads and therefore legal on read-only CSRs.
    assign does_write = (csr.CSR_OP == OP_RW) || (csr.CSR_OP[1] && !csr.CSR_NOWR);
    assign illegal    = csr.CSR_VALID &&
                        (!addr_hit || (does_write && (csr.CSR_ADDR[11:10] == 2'b11)));
    assign wr_en      = csr.CSR_VALID && !illegal && does_write;

    always_comb begin
        case (csr.CSR_OP)
            OP_RW:   new_val = csr.CSR_WDATA;
            OP_RS:   new_val = rd_val | csr.CSR_WDATA;
            OP_RC:   new_val = rd_val & ~csr.CSR_WDATA;
            default: new_val = rd_val;
        endcase
    end

    // A write to either half replaces that cycle's increment; the other half keeps its old value.
    always_comb begin
        mcycle_nxt = (mcycle_reg + 64'd1) & CNT_MASK;
        if (wr_en && (csr.CSR_ADDR == A_MCYCLE))
            mcycle_nxt = {mcycle_reg[63:32], new_val} & CNT_MASK;
        else if (wr_en && (csr.CSR_ADDR == A_MCYCLEH))
            mcycle_nxt = {new_val, mcycle_reg[31:0]} & CNT_MASK;

        minstret_nxt = INSTRET ? ((minstret_reg + 64'd1) & CNT_MASK) : minstret_reg;
        if (wr_en && (csr.CSR_ADDR == A_MINSTRET))
            minstret_nxt = {minstret_reg[63:32], new_val} & CNT_MASK;
        else if (wr_en && (csr.CSR_ADDR == A_MINSTRETH))
            minstret_nxt = {new_val, minstret_reg[31:0]} & CNT_MASK;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_reg      <= 32'h0;
            mtvec_reg    <= MTVEC_RST;
            mscratch_reg <= 32'h0;
            mepc_reg     <= 32'h0;
            mcause_reg   <= 32'h0;
            mtval_reg    <= 32'h0;
            mcycle_reg   <= 64'h0;
            minstret_reg <= 64'h0;
            rdata_reg    <= 32'h0;
            illegal_reg  <= 1'b0;
        end else begin
            if (wr_en && (csr.CSR_ADDR == A_MIE))
                mie_reg <= new_val & MIE_MASK;
            if (wr_en && (csr.CSR_ADDR == A_MTVEC))
                mtvec_reg <= new_val & ALIGN_MASK;
            if (wr_en && (csr.CSR_ADDR == A_MSCRATCH))
                mscratch_reg <= new_val;

            // Trap entry owns mepc/mcause/mtval/mstatus for the cycle; MRET owns mstatus.
            if (TRAP) begin
                mepc_reg     <= TRAP_PC & ALIGN_MASK;
                mcause_reg   <= TRAP_CAUSE;
                mtval_reg    <= TRAP_TVAL;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else begin
                if (MRET) begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end else if (wr_en && (csr.CSR_ADDR == A_MSTATUS)) begin
                    mstatus_mie  <= new_val[3];
                    mstatus_mpie <= new_val[7];
                end
                if (wr_en && (csr.CSR_ADDR == A_MEPC))
                    mepc_reg <= new_val & ALIGN_MASK;
                if (wr_en && (csr.CSR_ADDR == A_MCAUSE))
                    mcause_reg <= new_val;
                if (wr_en && (csr.CSR_ADDR == A_MTVAL))
                    mtval_reg <= new_val;
            end

            mcycle_reg   <= mcycle_nxt;
            minstret_reg <= minstret_nxt;

            if (csr.CSR_VALID)
                rdata_reg <= illegal ? 32'h0 : rd_val;
            illegal_reg <= illegal;
        end
    end

    assign csr.CSR_RDATA   = rdata_reg;
    assign csr.CSR_ILLEGAL = illegal_reg;
    assign MTVEC_OUT       = mtvec_reg;
    assign MEPC_OUT        = mepc_reg;
    assign MIE_OUT         = mstatus_mie;

endmodule

// File: tb/tb_riscoffee_mcsr.sv
// Bench for riscoffee_mcsr: CSR ops push expected read results to a scoreboard queue,
// a monitor pops and compares one cycle later; side outputs are checked inline per task.
module tb_riscoffee_mcsr;

    logic        CLK;
    logic        RST_N;
    logic        INSTRET;
    logic        TRAP;
    logic [31:0] TRAP_PC;
    logic [31:0] TRAP_CAUSE;
    logic [31:0] TRAP_TVAL;
    logic        MRET;
    logic [31:0] MTVEC_OUT;
    logic [31:0] MEPC_OUT;
    logic        MIE_OUT;

    riscoffee_mcsr_if bus ();

    riscoffee_mcsr #(
        .HART_ID     (32'h0000_0003),
        .MISA_VALUE  (32'h4000_0100),
        .MTVEC_RESET (32'h0000_0103),
        .CNT_W       (64)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .csr        (bus.slave),
        .INSTRET    (INSTRET),
        .TRAP       (TRAP),
        .TRAP_PC    (TRAP_PC),
        .TRAP_CAUSE (TRAP_CAUSE),
        .TRAP_TVAL  (TRAP_TVAL),
        .MRET       (MRET),
        .MTVEC_OUT  (MTVEC_OUT),
        .MEPC_OUT   (MEPC_OUT),
        .MIE_OUT    (MIE_OUT)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] rdata;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] tb_cyc;
    logic [63:0] tb_ret;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference counts: cycles and retirements since the last reset.
    always @(posedge CLK) begin
        if (!RST_N) begin
            tb_cyc <= 64'h0;
            tb_ret <= 64'h0;
        end else begin
            tb_cyc <= tb_cyc + 64'd1;
            if (INSTRET) tb_ret <= tb_ret + 64'd1;
        end
    end

    logic mon_v;
    logic mon_r;
    exp_t mon_e;
    always @(posedge CLK) begin
        mon_v = bus.CSR_VALID;
        mon_r = RST_N;
        #1;
        if (mon_r === 1'b1) begin
            if (mon_v === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: response with no expected entry at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    if ({bus.CSR_ILLEGAL, bus.CSR_RDATA} !== {mon_e.ill, mon_e.rdata}) begin
                        errors++;
                        $display("FAIL csr_resp addr=%h: got rdata=%h ill=%b, expected rdata=%h ill=%b",
                                 mon_e.addr, bus.CSR_RDATA, bus.CSR_ILLEGAL, mon_e.rdata, mon_e.ill);
                    end
                end
            end else begin
                checks++;
                if (bus.CSR_ILLEGAL !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_illegal: got %b, expected 0", bus.CSR_ILLEGAL);
                end
            end
        end
    end

    task automatic drive_now(input logic [1:0] o, input logic nw, input logic [11:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ill);
        exp_t e;
        bus.CSR_VALID = 1'b1;
        bus.CSR_OP    = o;
        bus.CSR_NOWR  = nw;
        bus.CSR_ADDR  = a;
        bus.CSR_WDATA = wd;
        e.addr  = a;
        e.rdata = exp_rd;
        e.ill   = exp_ill;
        sb.push_back(e);
    endtask

    task automatic op(input logic [1:0] o, input logic nw, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ill);
        @(negedge CLK);
        TRAP = 1'b0;
        MRET = 1'b0;
        drive_now(o, nw, a, wd, exp_rd, exp_ill);
    endtask

    task automatic idle();
        @(negedge CLK);
        bus.CSR_VALID = 1'b0;
        TRAP = 1'b0;
        MRET = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.CSR_RDATA, bus.CSR_ILLEGAL} !== {32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_resp: got rdata=%h ill=%b, expected 0/0", bus.CSR_RDATA, bus.CSR_ILLEGAL);
        end
        checks++;
        if ({MTVEC_OUT, MEPC_OUT, MIE_OUT} !== {32'h0000_0100, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outs: got mtvec=%h mepc=%h mie=%b, expected 00000100/0/0",
                     MTVEC_OUT, MEPC_OUT, MIE_OUT);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_rw_rs();
        op(2'b01, 1'b0, 12'h340, 32'hDEADBEEF, 32'h0, 1'b0);
        op(2'b10, 1'b0, 12'h340, 32'h0000000F, 32'hDEADBEEF, 1'b0);
        op(2'b00, 1'b0, 12'h340, 32'h0, 32'hDEADBEEF, 1'b0);
        op(2'b10, 1'b1, 12'h340, 32'hFFFF0000, 32'hDEADBEEF, 1'b0);
        op(2'b11, 1'b1, 12'h340, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b0);
        op(2'b00, 1'b0, 12'h340, 32'h0, 32'hDEADBEEF, 1'b0);
        idle();
    endtask

    task automatic test_mstatus();
        op(2'b10, 1'b0, 12'h300, 32'h0000_0088, 32'h0000_1800, 1'b0);
        op(2'b11, 1'b0, 12'h300, 32'h0000_0008, 32'h0000_1888, 1'b0);
        idle();
        checks++;
        if (MIE_OUT !== 1'b0) begin
            errors++;
            $display("FAIL mstatus_rc_mie: got %b, expected 0", MIE_OUT);
        end
        op(2'b00, 1'b0, 12'h300, 32'h0, 32'h0000_1880, 1'b0);
        op(2'b01, 1'b0, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0);
        op(2'b00, 1'b0, 12'h304, 32'h0, 32'h0000_0888, 1'b0);
        op(2'b01, 1'b0, 12'h305, 32'h0000_1001, 32'h0000_0100, 1'b0);
        idle();
        checks++;
        if (MTVEC_OUT !== 32'h0000_1000) begin
            errors++;
            $display("FAIL mtvec_align: got %h, expected 00001000", MTVEC_OUT);
        end
    endtask

    task automatic test_illegal();
        op(2'b01, 1'b0, 12'hC00, 32'h0000_0055, 32'h0, 1'b1);
        @(negedge CLK);
        drive_now(2'b10, 1'b1, 12'hC00, 32'h0, tb_cyc[31:0], 1'b0);
        op(2'b00, 1'b0, 12'h7C0, 32'h0, 32'h0, 1'b1);
        op(2'b01, 1'b0, 12'h301, 32'h0, 32'h4000_0100, 1'b0);
        op(2'b00, 1'b0, 12'h301, 32'h0, 32'h4000_0100, 1'b0);
        op(2'b01, 1'b0, 12'h344, 32'hFFFF_FFFF, 32'h0, 1'b0);
        op(2'b00, 1'b0, 12'h344, 32'h0, 32'h0, 1'b0);
        op(2'b01, 1'b0, 12'hF14, 32'h1, 32'h0, 1'b1);
        op(2'b00, 1'b0, 12'hF11, 32'h0, 32'h0, 1'b0);
        op(2'b00, 1'b0, 12'hF14, 32'h0, 32'h0000_0003, 1'b0);
        idle();
        idle();
        checks++;
        if (bus.CSR_RDATA !== 32'h0000_0003) begin
            errors++;
            $display("FAIL idle_hold: got %h, expected 00000003", bus.CSR_RDATA);
        end
    endtask

    task automatic test_counter_carry();
        @(negedge CLK);
        drive_now(2'b01, 1'b0, 12'hB00, 32'hFFFF_FFFF, tb_cyc[31:0], 1'b0);
        op(2'b01, 1'b0, 12'hB80, 32'h0, 32'h0, 1'b0);
        idle();
        op(2'b00, 1'b0, 12'hB80, 32'h0, 32'h1, 1'b0);
        op(2'b00, 1'b0, 12'hB00, 32'h0, 32'h1, 1'b0);
        op(2'b00, 1'b0, 12'hC00, 32'h0, 32'h2, 1'b0);
        op(2'b00, 1'b0, 12'hC80, 32'h0, 32'h1, 1'b0);
        idle();
    endtask

    task automatic test_trap_mret();
        op(2'b01, 1'b0, 12'h300, 32'h0000_0008, 32'h0000_1880, 1'b0);
        @(negedge CLK);
        TRAP       = 1'b1;
        TRAP_PC    = 32'h8000_0107;
        TRAP_CAUSE = 32'd11;
        TRAP_TVAL  = 32'h0000_1234;
        drive_now(2'b01, 1'b0, 12'h341, 32'h5, 32'h0, 1'b0);
        idle();
        checks++;
        if ({MEPC_OUT, MIE_OUT} !== {32'h8000_0104, 1'b0}) begin
            errors++;
            $display("FAIL trap_entry: got mepc=%h mie=%b, expected 80000104/0", MEPC_OUT, MIE_OUT);
        end
        op(2'b00, 1'b0, 12'h342, 32'h0, 32'd11, 1'b0);
        op(2'b00, 1'b0, 12'h343, 32'h0, 32'h0000_1234, 1'b0);
        op(2'b00, 1'b0, 12'h300, 32'h0, 32'h0000_1880, 1'b0);
        @(negedge CLK);
        MRET = 1'b1;
        drive_now(2'b01, 1'b0, 12'h300, 32'h0, 32'h0000_1880, 1'b0);
        idle();
        checks++;
        if (MIE_OUT !== 1'b1) begin
            errors++;
            $display("FAIL mret_mie: got %b, expected 1", MIE_OUT);
        end
        op(2'b00, 1'b0, 12'h300, 32'h0, 32'h0000_1888, 1'b0);
        op(2'b01, 1'b0, 12'h341, 32'h0000_1237, 32'h8000_0104, 1'b0);
        idle();
        checks++;
        if (MEPC_OUT !== 32'h0000_1234) begin
            errors++;
            $display("FAIL mepc_write: got %h, expected 00001234", MEPC_OUT);
        end
    endtask

    task automatic test_instret();
        logic [31:0] r;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            INSTRET = (i % 3 != 1);
        end
        @(negedge CLK);
        INSTRET = 1'b0;
        r = tb_ret[31:0];
        drive_now(2'b00, 1'b0, 12'hB02, 32'h0, r, 1'b0);
        @(negedge CLK);
        INSTRET = 1'b1;
        drive_now(2'b01, 1'b0, 12'hB82, 32'h7, 32'h0, 1'b0);
        @(negedge CLK);
        INSTRET = 1'b0;
        drive_now(2'b00, 1'b0, 12'hC82, 32'h0, 32'h7, 1'b0);
        op(2'b00, 1'b0, 12'hC02, 32'h0, r, 1'b0);
        idle();
    endtask

    task automatic test_reset_midrun();
        op(2'b01, 1'b0, 12'h340, 32'h0000_ABCD, 32'hDEADBEEF, 1'b0);
        @(negedge CLK);
        RST_N         = 1'b0;
        INSTRET       = 1'b1;
        TRAP          = 1'b1;
        bus.CSR_VALID = 1'b1;
        bus.CSR_OP    = 2'b01;
        bus.CSR_ADDR  = 12'h340;
        bus.CSR_WDATA = 32'h1111_1111;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if ({bus.CSR_RDATA, MTVEC_OUT, MEPC_OUT} !== {32'h0, 32'h0000_0100, 32'h0}) begin
            errors++;
            $display("FAIL midrun_reset: got rdata=%h mtvec=%h mepc=%h, expected 0/00000100/0",
                     bus.CSR_RDATA, MTVEC_OUT, MEPC_OUT);
        end
        TRAP  = 1'b0;
        RST_N = 1'b1;
        drive_now(2'b00, 1'b0, 12'hB00, 32'h0, 32'h0, 1'b0);
        op(2'b00, 1'b0, 12'hB02, 32'h0, 32'h1, 1'b0);
        op(2'b00, 1'b0, 12'h340, 32'h0, 32'h0, 1'b0);
        INSTRET = 1'b0;
        idle();
        checks++;
        if ({MTVEC_OUT, MIE_OUT} !== {32'h0000_0100, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_outs: got mtvec=%h mie=%b, expected 00000100/0", MTVEC_OUT, MIE_OUT);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N         = 1'b0;
        INSTRET       = 1'b0;
        TRAP          = 1'b0;
        TRAP_PC       = 32'h0;
        TRAP_CAUSE    = 32'h0;
        TRAP_TVAL     = 32'h0;
        MRET          = 1'b0;
        bus.CSR_VALID = 1'b0;
        bus.CSR_OP    = 2'b00;
        bus.CSR_NOWR  = 1'b0;
        bus.CSR_ADDR  = 12'h0;
        bus.CSR_WDATA = 32'h0;

        test_reset();
        test_rw_rs();
        test_mstatus();
        test_illegal();
        test_counter_carry();
        test_trap_mret();
        test_instret();
        test_reset_midrun();
        idle();
        idle();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscoffee_mcsr.md
Name: riscoffee_mcsr

Overview:
- Machine-mode CSR unit that replaces the flat 4096-entry CSR array with a sparse, spec-shaped register set.
- Provides:
  - registered atomic read-modify-write with the old value returned;
  - illegal-access detection;
  - 64-bit cycle and instret counters;
  - hardware trap entry and MRET state updates.
- Sits beside the execute stage: the decoder drives CSR operations, and the trap/retire logic drives the TRAP, MRET and INSTRET pulses.

Parameters:
- HART_ID, 0: value read from mhartid.
- MISA_VALUE, 32'h40000100: value read from misa (RV32I).
- MTVEC_RESET, 32'h00000000: reset value of mtvec; bits [1:0] forced to 0.
- CNT_W, 64: implemented counter width, legal range 32..64. Bits at and above CNT_W read 0.

Ports:
- CLK  in  1  clock
- RST_N  in  1  synchronous reset, active-low
- CSR_VALID  in  1  CSR instruction in this cycle
- CSR_OP  in  2  01 write (RW), 10 set (RS), 11 clear (RC), 00 is a no-op read
- CSR_NOWR  in  1  rs1/uimm field is zero; for RS/RC this suppresses the write
- CSR_ADDR  in  12  CSR address
- CSR_WDATA  in  32  operand
- CSR_RDATA  out  32  old CSR value, registered
- CSR_ILLEGAL  out  1  registered illegal-access flag
- INSTRET  in  1  one instruction retired this cycle
- TRAP  in  1  trap entry pulse
- TRAP_PC  in  32  faulting PC
- TRAP_CAUSE  in  32  mcause value
- TRAP_TVAL  in  32  mtval value
- MRET  in  1  mret executed
- MTVEC_OUT  out  32  current mtvec
- MEPC_OUT  out  32  current mepc
- MIE_OUT  out  1  current mstatus.MIE

Behaviour:
- Implemented addresses:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: writes are silently ignored (not illegal).
  - mie 0x304: bits 3, 7, 11 writable; others read 0.
  - mtvec 0x305: bits [1:0] read 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342 and mtval 0x343: full 32 bits.
  - mip 0x344: reads 0; writes ignored.
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82: writable.
  - cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82: read-only shadows of the machine counters.
  - mvendorid/marchid/mimpid 0xF11-0xF13: read 0.
  - mhartid 0xF14: reads HART_ID.
- An operation writes when CSR_OP==01, or when CSR_OP is 10/11 with CSR_NOWR==0.
- Illegal when CSR_VALID is high and either:
  - the address is unimplemented, or
  - the operation writes and ADDR[11:10]==2'b11.
  - An illegal access modifies nothing and CSR_RDATA still updates to 0.
- New value by operation:
  - RW: WDATA.
  - RS: old | WDATA.
  - RC: old & ~WDATA.
  - The result is then masked to the writable bits of the target CSR.
- Latency:
  - CSR_RDATA and CSR_ILLEGAL are registered one cycle after CSR_VALID.
  - CSR_RDATA carries the value before this cycle's update, including the pre-increment counter value.
  - With CSR_VALID low, CSR_RDATA holds its value and CSR_ILLEGAL goes to 0.
- Counters:
  - mcycle increments every cycle; minstret increments when INSTRET==1.
  - Both wrap modulo 2^CNT_W.
  - A CSR write to the low or high half replaces the increment for that counter in that cycle. The written half takes WDATA; the other half keeps its pre-increment value.
- Trap entry, when TRAP==1:
  - mepc <= TRAP_PC & ~3
  - mcause <= TRAP_CAUSE
  - mtval <= TRAP_TVAL
  - MPIE <= MIE
  - MIE <= 0
- MRET, when MRET==1 and TRAP==0: MIE <= MPIE, MPIE <= 1.
- Priority in the same cycle, per register: TRAP > MRET > CSR write. A lower-priority write to an affected register is dropped. A CSR read in that cycle still returns the pre-update value.
- Outputs MTVEC_OUT, MEPC_OUT and MIE_OUT are driven directly from the registers and reflect updates the cycle after the write.
- Reset (RST_N==0 at a clock edge):
  - every register is 0 except mtvec = MTVEC_RESET & ~3;
  - CSR_RDATA = 0, CSR_ILLEGAL = 0;
  - reset overrides every simultaneous event, and a counter resumes from 0 on the first cycle after reset.

Test Plan:
- RW 0x340 with 32'hDEADBEEF, then RS 0x340 with 32'h0000000F -> second result returns 32'hDEADBEEF; a following read returns 32'hDEADBEEF.
- RC 0x300 with WDATA=8 while MIE=1 -> RDATA=32'h00001888; MIE_OUT=0 the next cycle.
- RW 0xC00 (read-only) -> CSR_ILLEGAL=1 and cycle is unchanged. RS 0xC00 with CSR_NOWR=1 -> legal, returns the cycle count. Read of 0x7C0 -> CSR_ILLEGAL=1, RDATA=0.
- Write mcycle=32'hFFFFFFFF and mcycleh=0 -> two cycles later mcycleh reads 1 and mcycle reads 32'h00000001 (the carry has propagated).
- With MIE=1, assert TRAP with PC=32'h80000107, CAUSE=11 and, in the same cycle, CSR RW mepc=5 -> mepc=32'h80000104, mcause=11, MPIE=1, MIE=0. A later MRET -> MIE=1, MPIE=1.
- Assert RST_N low mid-run with INSTRET high -> minstret=0, mtvec=MTVEC_RESET, RDATA=0 the cycle after release.
